// File: rtl/ipnuma_dest_table.sv
// ipnuma_dest_table: local IPv4/MAC registers plus a NUM_ENTRY destination
// table on the PCIe slave bus, with a 2-stage physical-address lookup port.
module ipnuma_dest_table #(
   parameter  int NUM_ENTRY = 4,
   parameter  int WIN_BITS  = 28,
   parameter  int BAR_IDX   = 0,
   localparam int IW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
   input  logic                pcie_clk,
   input  logic                sys_rst_n,
   input  logic [6:0]          slv_bar_i,
   input  logic                slv_ce_i,
   input  logic                slv_we_i,
   input  logic [18:0]         slv_adr_i,
   input  logic [15:0]         slv_dat_i,
   input  logic [1:0]          slv_sel_i,
   output logic [15:0]         slv_dat_o,
   output logic [31:0]         if_v4addr,
   output logic [47:0]         if_macaddr,
   input  logic                lkup_req,
   input  logic [47:0]         lkup_paddr,
   output logic                lkup_ack,
   output logic                lkup_hit,
   output logic [IW-1:0]       lkup_idx,
   output logic [31:0]         lkup_v4addr,
   output logic [47:0]         lkup_macaddr,
   output logic [WIN_BITS-1:0] lkup_offset
);

   function automatic logic [15:0] bmerge(logic [15:0] old,
                                          logic [15:0] d,
                                          logic [1:0]  s);
      return {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
   endfunction

   logic [8:0]    adr;
   logic          acc, wr, rd;
   logic [5:0]    blk;
   logic          ent_map;
   logic [IW-1:0] eidx;
   logic          miss_clr;
   logic          unused_ok;

   assign adr       = slv_adr_i[8:0];
   assign acc       = slv_bar_i[BAR_IDX] & slv_ce_i;
   assign wr        = acc & slv_we_i;
   assign rd        = acc & ~slv_we_i;
   assign blk       = adr[8:3] - 6'd2;
   assign ent_map   = (adr[8:3] >= 6'd2) && (blk < 6'(NUM_ENTRY));
   assign eidx      = blk[IW-1:0];
   assign miss_clr  = wr && (adr == 9'h00A);
   assign unused_ok = ^{slv_adr_i[18:9], slv_bar_i};

   logic [31:0]          ifv4_q;
   logic [47:0]          ifmac_q;
   logic                 en_q;
   logic [NUM_ENTRY-1:0] valid_q, valid_nxt;
   logic [15:0]          miss_q;
   logic [15:0]          rd_q;
   logic [31:0]          v4_q  [NUM_ENTRY];
   logic [47:0]          mac_q [NUM_ENTRY];
   logic [47:0]          pa_q  [NUM_ENTRY];

   logic                 s1_v;
   logic [NUM_ENTRY-1:0] s1_match, match_c;
   logic [WIN_BITS-1:0]  s1_off;
   logic [IW-1:0]        s2_idx;
   logic                 s2_hit, s2_miss;

   // Entry writes drop VALID on the same edge so a half-written entry
   // never matches; stage 2 qualifies its hit with this next-state view.
   always_comb begin
      valid_nxt = valid_q;
      if (wr && adr == 9'h008) begin
         for (int i = 0; i < NUM_ENTRY; i++)
            if (slv_sel_i[i/8]) valid_nxt[i] = slv_dat_i[i];
      end
      if (wr && ent_map && |slv_sel_i) valid_nxt[eidx] = 1'b0;
   end

   logic [15:0]  rdata;
   logic [127:0] ent_rec;

   always_comb begin
      rdata   = '0;
      ent_rec = {v4_q[eidx], mac_q[eidx], pa_q[eidx]};
      unique case (1'b1)
         adr == 9'h000: rdata = ifv4_q[31:16];
         adr == 9'h001: rdata = ifv4_q[15:0];
         adr == 9'h002: rdata = ifmac_q[47:32];
         adr == 9'h003: rdata = ifmac_q[31:16];
         adr == 9'h004: rdata = ifmac_q[15:0];
         adr == 9'h007: rdata = {8'(NUM_ENTRY), 7'd0, en_q};
         adr == 9'h008: rdata = 16'(valid_q);
         adr == 9'h00A: rdata = miss_q;
         ent_map:       rdata = ent_rec[{~adr[2:0], 4'd0} +: 16];
         default:       rdata = '0;
      endcase
   end

   assign slv_dat_o = slv_bar_i[BAR_IDX] ? rd_q : 16'd0;

   always_ff @(posedge pcie_clk) begin
      if (!sys_rst_n) begin
         ifv4_q     <= 32'h0A00_15C7;
         ifmac_q    <= 48'h0037_7600_0001;
         en_q       <= 1'b1;
         valid_q    <= '0;
         valid_q[0] <= 1'b1;
         miss_q     <= '0;
         rd_q       <= '0;
         for (int i = 0; i < NUM_ENTRY; i++) begin
            v4_q[i]  <= (i == 0) ? 32'h0A00_15FF : 32'h0;
            mac_q[i] <= (i == 0) ? 48'hFFFF_FFFF_FFFF : 48'h0;
            pa_q[i]  <= (i == 0) ? 48'h0000_D000_0000 : 48'h0;
         end
      end else begin
         valid_q <= valid_nxt;
         if (rd) rd_q <= rdata;
         if (miss_clr)
            miss_q <= '0;
         else if (s2_miss && miss_q != 16'hFFFF)
            miss_q <= miss_q + 16'd1;
         if (wr) begin
            unique case (1'b1)
               adr == 9'h000:
                  ifv4_q[31:16] <= bmerge(ifv4_q[31:16], slv_dat_i, slv_sel_i);
               adr == 9'h001:
                  ifv4_q[15:0] <= bmerge(ifv4_q[15:0], slv_dat_i, slv_sel_i);
               adr == 9'h002:
                  ifmac_q[47:32] <= bmerge(ifmac_q[47:32], slv_dat_i, slv_sel_i);
               adr == 9'h003:
                  ifmac_q[31:16] <= bmerge(ifmac_q[31:16], slv_dat_i, slv_sel_i);
               adr == 9'h004:
                  ifmac_q[15:0] <= bmerge(ifmac_q[15:0], slv_dat_i, slv_sel_i);
               adr == 9'h007:
                  if (slv_sel_i[0]) en_q <= slv_dat_i[0];
               ent_map: begin
                  case (adr[2:0])
                     3'd0: v4_q[eidx][31:16] <=
                              bmerge(v4_q[eidx][31:16], slv_dat_i, slv_sel_i);
                     3'd1: v4_q[eidx][15:0] <=
                              bmerge(v4_q[eidx][15:0], slv_dat_i, slv_sel_i);
                     3'd2: mac_q[eidx][47:32] <=
                              bmerge(mac_q[eidx][47:32], slv_dat_i, slv_sel_i);
                     3'd3: mac_q[eidx][31:16] <=
                              bmerge(mac_q[eidx][31:16], slv_dat_i, slv_sel_i);
                     3'd4: mac_q[eidx][15:0] <=
                              bmerge(mac_q[eidx][15:0], slv_dat_i, slv_sel_i);
                     3'd5: pa_q[eidx][47:32] <=
                              bmerge(pa_q[eidx][47:32], slv_dat_i, slv_sel_i);
                     3'd6: pa_q[eidx][31:16] <=
                              bmerge(pa_q[eidx][31:16], slv_dat_i, slv_sel_i);
                     default: pa_q[eidx][15:0] <=
                              bmerge(pa_q[eidx][15:0], slv_dat_i, slv_sel_i);
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_ENTRY; i++)
         match_c[i] = en_q & valid_q[i] &
                      (lkup_paddr[47:WIN_BITS] == pa_q[i][47:WIN_BITS]);
   end

   // Lowest matching index wins.
   always_comb begin
      s2_idx = '0;
      for (int i = NUM_ENTRY - 1; i >= 0; i--)
         if (s1_match[i]) s2_idx = IW'(i);
      s2_hit = (|s1_match) & valid_nxt[s2_idx];
   end

   assign s2_miss = s1_v & ~s2_hit;

   always_ff @(posedge pcie_clk) begin
      if (!sys_rst_n) begin
         if_v4addr    <= 32'h0A00_15C7;
         if_macaddr   <= 48'h0037_7600_0001;
         s1_v         <= 1'b0;
         s1_match     <= '0;
         s1_off       <= '0;
         lkup_ack     <= 1'b0;
         lkup_hit     <= 1'b0;
         lkup_idx     <= '0;
         lkup_v4addr  <= '0;
         lkup_macaddr <= '0;
         lkup_offset  <= '0;
      end else begin
         if_v4addr  <= ifv4_q;
         if_macaddr <= ifmac_q;
         s1_v       <= lkup_req;
         if (lkup_req) begin
            s1_match <= match_c;
            s1_off   <= lkup_paddr[WIN_BITS-1:0];
         end
         lkup_ack <= s1_v;
         if (s1_v) begin
            lkup_hit     <= s2_hit;
            lkup_idx     <= s2_hit ? s2_idx : '0;
            lkup_v4addr  <= s2_hit ? v4_q[s2_idx] : 32'h0;
            lkup_macaddr <= s2_hit ? mac_q[s2_idx] : 48'h0;
            lkup_offset  <= s1_off;
         end
      end
   end

endmodule

// File: doc/ipnuma_dest_table.md
# ipnuma_dest_table

Parametrised successor to the single-destination BAR register block. It holds the local interface IPv4/MAC addresses and a table of NUM_ENTRY remote destinations (IPv4, MAC, physical window base), all programmed over the PCIe slave bus. It also serves a pipelined physical-address lookup port that the requester uses to pick the destination for each outgoing memory TLP. It sits between pcie_tlp (slave bus) and requester (lookup port), in the pcie_clk domain.

## Interface
- NUM_ENTRY, 4, number of destination entries; power of two, 1..16; IW = max(1, log2(NUM_ENTRY)).
- WIN_BITS, 28, log2 of the byte size of each entry's physical window, 12..40.
- BAR_IDX, 0, slv_bar_i bit this block decodes.
- pcie_clk  in  1  sole clock.
- sys_rst_n  in  1  synchronous, active-low reset.
- slv_bar_i  in  7  BAR hit vector.
- slv_ce_i  in  1  bus cycle strobe.
- slv_we_i  in  1  1 = write, 0 = read.
- slv_adr_i  in  19  word address [19:1]; only [9:1] is decoded.
- slv_dat_i  in  16  write data.
- slv_sel_i  in  2  byte enables: [0] = bits 7:0, [1] = bits 15:8.
- slv_dat_o  out  16  read data; forced to 0 while slv_bar_i[BAR_IDX]=0, so it can be OR-merged.
- if_v4addr  out  32  interface IPv4 address.
- if_macaddr  out  48  interface MAC address.
- lkup_req  in  1  lookup request, one per cycle, no backpressure.
- lkup_paddr  in  48  physical address to look up.
- lkup_ack  out  1  result valid, one pulse per request.
- lkup_hit  out  1  a matching valid entry was found.
- lkup_idx  out  IW  index of the matching entry.
- lkup_v4addr  out  32  destination IPv4 of the matching entry.
- lkup_macaddr  out  48  destination MAC of the matching entry.
- lkup_offset  out  WIN_BITS  lkup_paddr[WIN_BITS-1:0].

## Operation
- **Access rule:** an access occurs when slv_bar_i[BAR_IDX] & slv_ce_i. Writes honour slv_sel_i per byte. Multi-word fields are high word first.
- **Register map** (word addresses, slv_adr_i[9:1]):
  - 0x000–0x001: if_v4addr.
  - 0x002–0x004: if_macaddr.
  - 0x007: CTRL. bit0 = EN (RW); bits15:8 = NUM_ENTRY (RO); other bits read 0.
  - 0x008: VALID mask (RW). Bits at or above NUM_ENTRY read 0 and ignore writes.
  - 0x00A: MISS counter. 16-bit, saturates at 0xFFFF; any write clears it.
  - 0x010 + 8·e: entry e. +0..+1 = v4addr, +2..+4 = macaddr, +5..+7 = paddr[47:0].
- **Unmapped addresses:** reads return 0; writes are ignored. This includes entries e ≥ NUM_ENTRY.
- **Auto-invalidate:** any write to an entry field with a nonzero slv_sel_i clears VALID[e] on the same edge. A half-programmed entry can therefore never match. Software sets VALID again afterwards.
- **Match rule:** entry i matches when EN & VALID[i] & (lkup_paddr[47:WIN_BITS] == paddr_i[47:WIN_BITS]).
- **Priority:** when several entries match, the lowest index wins.
- **Miss result:** lkup_hit=0, lkup_idx=0, lkup_v4addr=0, lkup_macaddr=0. lkup_offset is still driven. MISS increments by 1 (saturating).
- **Counter conflict:** if a miss and a MISS write land on the same edge, the clear wins and the result is 0.

## Timing
- **Reset values:**
  - Bus and lookup outputs: slv_dat_o=0, lkup_ack=0, lkup_hit=0, lkup_idx=0, lkup_v4addr=0, lkup_macaddr=0, lkup_offset=0.
  - Interface: if_v4addr=10.0.21.199, if_macaddr=00:37:76:00:00:01.
  - Control: EN=1, VALID=0x0001, MISS=0.
  - Entry 0: v4addr=10.0.21.255, macaddr=FF:FF:FF:FF:FF:FF, paddr=0x0000_D000_0000.
  - Entries 1..N-1: all zero.
- **Reset mid-lookup:** in-flight requests are dropped and produce no ack.
- **Read latency:** 1 cycle. The read-data register loads on the edge that samples the access. It holds its value until the next read; writes do not update it.
- **Write latency:** a write takes effect on the sampling edge. if_v4addr and if_macaddr update the following cycle.
- **Lookup pipeline:** 2 stages, fully pipelined.
  - Request sampled at edge T.
  - Edge T: stage 1 registers lkup_paddr and the match vector from the table state before T.
  - Edge T+1: stage 2 priority-encodes and registers the results.
  - lkup_ack is high during cycle T+1..T+2, exactly 1 cycle.
  - Back-to-back requests give back-to-back acks, in order.
- **Stage-2 data source:** stage 2 reads entry fields from the live table. lkup_hit additionally requires VALID[idx] still set at T+1. A write to the selected entry between sampling and output therefore forces a miss and counts in MISS.

## Test plan
- **Reset defaults:** reset, then read 0x000, 0x001, 0x007, 0x008 → 0x0A00, 0x15C7, 0x0401 (NUM_ENTRY=4), 0x0001. lkup_paddr=0xD123_4567 → ack at +2 with hit=1, idx=0, MAC FF..FF, offset=0x0123_4567.
- **Byte-lane writes:** write 0x002 = 0xAABB with sel=2'b10 → read returns 0xAA37. if_macaddr[47:32] = 0xAA37 one cycle later.
- **Priority:** program entry 2 paddr=0x0000_E000_0000 and entry 1 to the same window, then set VALID=0x0007. Lookup 0xE000_0010 → idx=1, offset=0x10. Clear VALID bit 1 → idx=2.
- **Auto-invalidate race:** issue a lookup hitting entry 2 and, on the next cycle, write entry 2's +0 field. Required: ack with hit=0, VALID reads 0x0003, MISS increments by 1.
- **Miss counter:** 3 back-to-back misses → 3 consecutive ack pulses, MISS=3. A write to 0x00A coinciding with a miss → MISS=0. Preset near 0xFFFF → MISS saturates at 0xFFFF.
- **Enable and unmapped:** EN=0 → every lookup misses. Read 0x030 (entry 4, NUM_ENTRY=4) → 0. slv_bar_i[BAR_IDX]=0 → slv_dat_o=0 regardless of register state.
